clic_irq_target: RTL and testbench

CLIC_IRQ_TARGET -- requirements
Module: clic_irq_target

---
 rtl/clic_irq_target.sv | 131 +++++++++++++
 tb/tb_clic_irq_target.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_target.sv
// Single-target interrupt presenter: per-source edge/level pending cells, a
// level/id arbiter, and a two-state handshake toward one core.

module clic_src_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src,
  input  logic ie,
  input  logic trig_edge,
  input  logic clr,
  output logic pend
);
  logic src_q, ep;

  // A new edge in the same cycle as the ack clear keeps ep set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= 1'b0;
      ep    <= 1'b0;
    end else begin
      src_q <= src;
      ep    <= (src & ~src_q & trig_edge) | (ep & ~clr);
    end
  end

  // Masking only gates pend; ep survives ie being cleared.
  assign pend = ie & (trig_edge ? ep : src_q);
endmodule

module clic_irq_target #(
  parameter int unsigned NumSrc = 64,
  localparam int unsigned IdW   = $clog2(NumSrc)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumSrc-1:0]   src_i,
  input  logic [NumSrc-1:0]   ie_i,
  input  logic [NumSrc-1:0]   trig_edge_i,
  input  logic [NumSrc*8-1:0] level_i,
  output logic [NumSrc-1:0]   irq_o,
  output logic [7:0]          irq_level_o,
  input  logic                irq_ack_i,
  output logic [IdW-1:0]      irq_id_o
);
  typedef enum logic {IDLE, PRESENT} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    id_q, win_id;
  logic [7:0]        lvl_q, win_lvl;
  logic              win_any, beats, load, ack_clr;
  logic [NumSrc-1:0] pend, clr;

  for (genvar k = 0; k < NumSrc; k++) begin : g_src
    clic_src_cell u_cell (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .src       (src_i[k]),
      .ie        (ie_i[k]),
      .trig_edge (trig_edge_i[k]),
      .clr       (clr[k]),
      .pend      (pend[k])
    );
  end

  // Ascending scan with >= so the highest id wins a level tie.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    win_lvl = '0;
    for (int k = 0; k < NumSrc; k++) begin
      if (pend[k] && (!win_any || level_i[8*k +: 8] >= win_lvl)) begin
        win_any = 1'b1;
        win_id  = IdW'(k);
        win_lvl = level_i[8*k +: 8];
      end
    end
  end

  assign beats = win_any && ((win_lvl > lvl_q) || (win_lvl == lvl_q && win_id > id_q));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ack_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack_i) begin
          ack_clr = 1'b1;
          state_d = IDLE;
        end else if (!pend[id_q] || beats) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr       = '0;
    clr[id_q] = ack_clr & trig_edge_i[id_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q  <= win_id;
        lvl_q <= win_lvl;
      end
    end
  end

  // Driven from registers only, so ack never reaches irq_o combinationally.
  always_comb begin
    irq_o = '0;
    if (state_q == PRESENT) irq_o[id_q] = 1'b1;
  end

  assign irq_level_o = lvl_q;
  assign irq_id_o    = id_q;
endmodule

// File: tb/tb_clic_irq_target.sv
// Directed vector table plus hand sequences and a randomized invariant phase
// for clic_irq_target with 64 sources.

module tb_clic_irq_target;
  localparam int N  = 64;
  localparam int IW = 6;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   src_i, ie_i, trig_edge_i, irq_o;
  logic [N*8-1:0] level_i;
  logic           irq_ack_i;
  logic [7:0]     irq_level_o;
  logic [IW-1:0]  irq_id_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string        name;
    logic [N-1:0] src;
    logic         ack;
    logic [N-1:0] irq;
    logic [IW-1:0] id;
    logic [7:0]   lvl;
  } vec_t;

  vec_t vt [23];

  clic_irq_target #(.NumSrc(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .src_i       (src_i),
    .ie_i        (ie_i),
    .trig_edge_i (trig_edge_i),
    .level_i     (level_i),
    .irq_o       (irq_o),
    .irq_level_o (irq_level_o),
    .irq_ack_i   (irq_ack_i),
    .irq_id_o    (irq_id_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [N-1:0] b(input int k);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << k;
  endfunction

  task automatic check(input string name, input logic [N-1:0] irq,
                       input logic [IW-1:0] id, input logic [7:0] lvl);
    n_chk++;
    if (irq_o !== irq || irq_id_o !== id || irq_level_o !== lvl) begin
      n_fail++;
      $display("FAIL %s: got irq=%h id=%0d lvl=%h, want irq=%h id=%0d lvl=%h",
               name, irq_o, irq_id_o, irq_level_o, irq, id, lvl);
    end
  endtask

  task automatic step(input logic [N-1:0] s, input logic a);
    src_i     = s;
    irq_ack_i = a;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input int k, input logic en, input logic edg, input logic [7:0] l);
    ie_i[k]          = en;
    trig_edge_i[k]   = edg;
    level_i[8*k +: 8] = l;
  endtask

  logic [N-1:0]  prev_irq;
  logic [IW-1:0] prev_id;
  logic [7:0]    prev_lvl;

  initial begin
    src_i = '0; ie_i = '0; trig_edge_i = '0; level_i = '0; irq_ack_i = 1'b0;
    // Each row: inputs for one cycle, then expected outputs after that edge.
    vt[0]  = '{"reset_idle",     '0,             1'b0, '0,   6'd0, 8'h00};
    vt[1]  = '{"e5_rise",        b(5),           1'b0, '0,   6'd0, 8'h00};
    vt[2]  = '{"e5_present",     '0,             1'b0, b(5), 6'd5, 8'h40};
    vt[3]  = '{"e5_hold",        '0,             1'b0, b(5), 6'd5, 8'h40};
    vt[4]  = '{"e5_ack",         '0,             1'b1, '0,   6'd5, 8'h40};
    vt[5]  = '{"e5_no_repr0",    '0,             1'b0, '0,   6'd5, 8'h40};
    vt[6]  = '{"e5_no_repr1",    '0,             1'b0, '0,   6'd5, 8'h40};
    vt[7]  = '{"l3_l9_rise",     b(3) | b(9),    1'b0, '0,   6'd5, 8'h40};
    vt[8]  = '{"tie_hi_id",      b(3) | b(9),    1'b0, b(9), 6'd9, 8'h20};
    vt[9]  = '{"tie_hold",       b(3) | b(9),    1'b0, b(9), 6'd9, 8'h20};
    vt[10] = '{"ack9_drop9",     b(3),           1'b1, '0,   6'd9, 8'h20};
    vt[11] = '{"l3_present",     b(3),           1'b0, b(3), 6'd3, 8'h20};
    vt[12] = '{"ack3_drop3",     '0,             1'b1, '0,   6'd3, 8'h20};
    vt[13] = '{"idle_after3",    '0,             1'b0, '0,   6'd3, 8'h20};
    vt[14] = '{"e2_rise",        b(2),           1'b0, '0,   6'd3, 8'h20};
    vt[15] = '{"e2_present",     b(2),           1'b0, b(2), 6'd2, 8'h10};
    vt[16] = '{"e7_rise",        b(2) | b(7),    1'b0, b(2), 6'd2, 8'h10};
    vt[17] = '{"preempt_gap",    b(2) | b(7),    1'b0, '0,   6'd2, 8'h10};
    vt[18] = '{"e7_present",     b(2) | b(7),    1'b0, b(7), 6'd7, 8'h80};
    vt[19] = '{"ack7",           b(2) | b(7),    1'b1, '0,   6'd7, 8'h80};
    vt[20] = '{"e2_represent",   b(2) | b(7),    1'b0, b(2), 6'd2, 8'h10};
    vt[21] = '{"ack2",           '0,             1'b1, '0,   6'd2, 8'h10};
    vt[22] = '{"idle_after2",    '0,             1'b0, '0,   6'd2, 8'h10};

    cfg(2, 1'b1, 1'b1, 8'h10);
    cfg(3, 1'b1, 1'b0, 8'h20);
    cfg(4, 1'b1, 1'b0, 8'h30);
    cfg(5, 1'b1, 1'b1, 8'h40);
    cfg(7, 1'b1, 1'b1, 8'h80);
    cfg(9, 1'b1, 1'b0, 8'h20);

    src_i = b(5);
    repeat (3) @(posedge clk_i);
    #1;
    check("in_reset", '0, '0, '0);
    src_i  = '0;
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vt[i].src, vt[i].ack);
      check(vt[i].name, vt[i].irq, vt[i].id, vt[i].lvl);
    end

    // Level source withdrawn before ack.
    step(b(4), 1'b0); check("l4_rise",     '0,   6'd2, 8'h10);
    step(b(4), 1'b0); check("l4_present",  b(4), 6'd4, 8'h30);
    step('0,   1'b0); check("l4_drop",     b(4), 6'd4, 8'h30);
    step('0,   1'b0); check("l4_withdraw", '0,   6'd4, 8'h30);
    step('0,   1'b0); check("l4_stay_idle",'0,   6'd4, 8'h30);

    // Ack and a new rising edge on the presented source in the same cycle.
    step(b(5), 1'b0); check("e5b_rise",    '0,   6'd4, 8'h30);
    step('0,   1'b0); check("e5b_present", b(5), 6'd5, 8'h40);
    step('0,   1'b0); check("e5b_hold",    b(5), 6'd5, 8'h40);
    step(b(5), 1'b1); check("ack_and_edge",'0,   6'd5, 8'h40);
    step(b(5), 1'b0); check("e5b_repr",    b(5), 6'd5, 8'h40);
    step('0,   1'b1); check("e5b_ack",     '0,   6'd5, 8'h40);
    step('0,   1'b0); check("e5b_idle",    '0,   6'd5, 8'h40);

    // Asynchronous reset while presenting.
    step(b(5), 1'b0); check("e5c_rise",    '0,   6'd5, 8'h40);
    step('0,   1'b0); check("e5c_present", b(5), 6'd5, 8'h40);
    rst_ni = 1'b0;
    #1;
    check("async_reset", '0, '0, '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b0); check("post_reset_quiet", '0, '0, '0);
    end

    // Masked edge stays pending and appears once re-enabled.
    ie_i[5] = 1'b0;
    step(b(5), 1'b0); check("mask_rise",  '0, '0, '0);
    step('0,   1'b0); check("mask_hold0", '0, '0, '0);
    step('0,   1'b0); check("mask_hold1", '0, '0, '0);
    ie_i[5] = 1'b1;
    step('0,   1'b0); check("unmask_present", b(5), 6'd5, 8'h40);
    step('0,   1'b1); check("unmask_ack",     '0,   6'd5, 8'h40);

    // Random phase: one-hot and hold-stable invariants every cycle.
    prev_irq = irq_o; prev_id = irq_id_o; prev_lvl = irq_level_o;
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        ie_i        = {48'b0, 16'($urandom)};
        trig_edge_i = {48'b0, 16'($urandom)};
      end
      for (int k = 0; k < 16; k++) level_i[8*k +: 8] = 8'($urandom_range(0, 3));
      step({48'b0, 16'($urandom)}, ($urandom_range(0, 3) == 0));
      n_chk++;
      if (!$onehot0(irq_o)) begin
        n_fail++;
        $display("FAIL rnd_onehot0 cycle %0d: irq=%h", c, irq_o);
      end
      n_chk++;
      if (irq_o != '0 && irq_o != b(int'(irq_id_o))) begin
        n_fail++;
        $display("FAIL rnd_id_match cycle %0d: irq=%h id=%0d", c, irq_o, irq_id_o);
      end
      if (prev_irq != '0 && irq_o != '0) begin
        n_chk++;
        if (irq_id_o !== prev_id || irq_level_o !== prev_lvl) begin
          n_fail++;
          $display("FAIL rnd_stable cycle %0d: id=%0d lvl=%h, want id=%0d lvl=%h",
                   c, irq_id_o, irq_level_o, prev_id, prev_lvl);
        end
      end
      prev_irq = irq_o; prev_id = irq_id_o; prev_lvl = irq_level_o;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
